// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package cpu_mem_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned DEF_TIMEOUT      = 64;
  localparam int unsigned DEF_MAX_DM_BURST = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Command presented to the memory on a grant
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data wins unless a waiting fetch has been starved long enough.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   streak_full,
  output logic   grant_c,
  output owner_t owner_c
);

  // Pick the owner of the next memory access
  always_comb begin
    grant_c = if_req | dm_req;
    owner_c = OWN_DM;
    if (if_req && (!dm_req || streak_full)) begin
      owner_c = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned MAX_DM_BURST = DEF_MAX_DM_BURST
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  output logic            dm_ack_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned STK_W = $clog2(MAX_DM_BURST + 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STK_W-1:0]  streak_q, streak_d;

  logic              grant_c;
  owner_t            grant_own_c;
  logic              streak_full_c;
  logic              timeout_c;
  logic              done_c;
  logic              grant_en_c;
  mem_cmd_t          cmd_c;
  logic [XLEN-1:0]   rsp_rdata_c;

  assign streak_full_c = (streak_q == STK_W'(MAX_DM_BURST));
  assign timeout_c     = (state_q == BUSY) && !mem_ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done_c        = (state_q == BUSY) && (mem_ack_i || timeout_c);
  assign stall_o       = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  mem_arb_pick u_pick (
    .if_req      (if_req_i),
    .dm_req      (dm_req_i),
    .streak_full (streak_full_c),
    .grant_c     (grant_c),
    .owner_c     (grant_own_c)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_c) state_d = BUSY;
      BUSY:    if (done_c)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: grant command, streak update and response data
  always_comb begin
    grant_en_c  = 1'b0;
    cmd_c       = '0;
    streak_d    = streak_q;
    rsp_rdata_c = '0;
    unique case (state_q)
      IDLE: begin
        grant_en_c = grant_c;
        if (grant_own_c == OWN_DM) begin
          cmd_c.we    = dm_we_i;
          cmd_c.addr  = dm_addr_i;
          cmd_c.wdata = dm_wdata_i;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (!streak_full_c) begin
            streak_d = streak_q + STK_W'(1);
          end
        end else begin
          cmd_c.addr = if_addr_i;
          streak_d   = '0;
        end
      end
      BUSY: begin
        if (mem_ack_i && !mem_we_o) begin
          rsp_rdata_c = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  // Registered memory handshake, counters and requester responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      streak_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      if (grant_en_c) begin
        owner_q     <= grant_own_c;
        cnt_q       <= '0;
        streak_q    <= streak_d;
        mem_req_o   <= 1'b1;
        mem_we_o    <= cmd_c.we;
        mem_addr_o  <= cmd_c.addr;
        mem_wdata_o <= cmd_c.wdata;
      end else if (done_c) begin
        mem_req_o <= 1'b0;
        if (owner_q == OWN_DM) begin
          dm_ack_o   <= 1'b1;
          dm_rdata_o <= rsp_rdata_c;
        end else begin
          if_ack_o   <= 1'b1;
          if_rdata_o <= rsp_rdata_c;
        end
        if (timeout_c) begin
          err_o <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
